// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder family: mode encodings, FSM states and a
// one-hot helper sized for the widest legal decoder (N = 6).
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_N    = 6;
    localparam int MAX_OUTW = 1 << MAX_N;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    // Callers truncate the result to their own output width.
    function automatic logic [MAX_OUTW-1:0] onehot(input int unsigned index);
        return {{(MAX_OUTW-1){1'b0}}, 1'b1} << index;
    endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control/status bundle of decoder_scan_n; the master drives the controls.
interface decoder_scan_n_if #(
    parameter int N       = 2,
    parameter int DWELL_W = 8
);
    localparam int OUTW = 1 << N;

    logic               en;
    logic               mode;
    logic [N-1:0]       sel;
    logic               sel_valid;
    logic [DWELL_W-1:0] dwell;
    logic [OUTW-1:0]    q;
    logic [N-1:0]       idx;
    logic               wrap;

    modport master (
        output en, mode, sel, sel_valid, dwell,
        input  q, idx, wrap
    );

    modport slave (
        input  en, mode, sel, sel_valid, dwell,
        output q, idx, wrap
    );
endinterface

// File: rtl/decoder_n.sv
// Purely combinational N-to-2^N one-hot decoder with enable.
module decoder_n
    import decoder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                en,
    input  logic [N-1:0]        sel,
    output logic [(1 << N)-1:0] y
);
    localparam int OUTW = 1 << N;

    always_comb begin
        y = '0;
        if (en) begin
            y = OUTW'(onehot(32'(sel)));
        end
    end
endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with DIRECT (validated select) and SCAN (dwell-timed
// walk over all outputs) modes.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input logic            clk,
    input logic            rst,
    decoder_scan_n_if.slave bus
);
    localparam int            OUTW     = 1 << N;
    localparam logic [N-1:0]  IDX_LAST = N'(OUTW - 1);

    state_t             state;
    state_t             state_nxt;
    logic [N-1:0]       idx;
    logic [N-1:0]       idx_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic               on_nxt;
    logic               wrap_nxt;
    logic               wrap_r;
    logic [OUTW-1:0]    q_nxt;
    logic [OUTW-1:0]    q_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_OFF;
        if (bus.en) begin
            state_nxt = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    // Computes the values the registers take on this edge, keyed by the state being entered.
    always_comb begin
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        on_nxt   = 1'b0;
        unique case (state_nxt)
            ST_DIRECT: begin
                on_nxt = 1'b1;
                if (bus.sel_valid) begin
                    idx_nxt = bus.sel;
                end
            end
            ST_SCAN: begin
                on_nxt = 1'b1;
                if (state != ST_SCAN) begin
                    idx_nxt = '0;
                    cnt_nxt = bus.dwell;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end else begin
                    idx_nxt  = idx + N'(1);
                    cnt_nxt  = bus.dwell;
                    wrap_nxt = (idx == IDX_LAST);
                end
            end
            default: begin
                on_nxt = 1'b0;
            end
        endcase
    end

    decoder_n #(.N(N)) u_dec (
        .en  (on_nxt),
        .sel (idx_nxt),
        .y   (q_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            idx    <= '0;
            cnt    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            wrap_r <= wrap_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.idx  = idx;
    assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: N=2 checked every cycle against a behavioural
// model plus literal expectations; N=1 and N=3 exercise scan sweeps.
module tb_decoder_scan_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decoder_scan_n_if #(.N(1), .DWELL_W(8)) b1 ();
    decoder_scan_n_if #(.N(2), .DWELL_W(8)) b2 ();
    decoder_scan_n_if #(.N(3), .DWELL_W(8)) b3 ();

    decoder_scan_n #(.N(1), .DWELL_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    decoder_scan_n #(.N(2), .DWELL_W(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    decoder_scan_n #(.N(3), .DWELL_W(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model of the N=2 instance: which mode we are in, the index shown, and how
    // many more cycles the current scan index must still be held.
    int m_md   = 0;   // 0 off, 1 direct, 2 scan
    int m_idx  = 0;
    int m_left = 0;
    bit m_on   = 1'b0;
    bit m_wrap = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_md <= 0; m_idx <= 0; m_left <= 0; m_on <= 1'b0; m_wrap <= 1'b0;
        end else if (!b2.en) begin
            m_md <= 0; m_on <= 1'b0; m_wrap <= 1'b0;
        end else if (b2.mode == 1'b0) begin
            m_md <= 1; m_on <= 1'b1; m_wrap <= 1'b0;
            if (b2.sel_valid) m_idx <= int'(b2.sel);
        end else begin
            m_md <= 2; m_on <= 1'b1;
            if (m_md != 2) begin
                m_idx <= 0; m_left <= int'(b2.dwell); m_wrap <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1; m_wrap <= 1'b0;
            end else begin
                m_idx <= (m_idx + 1) % 4; m_left <= int'(b2.dwell); m_wrap <= (m_idx == 3);
            end
        end
    end

    bit prev_wrap2 = 1'b0;

    always @(negedge clk) begin
        chk("model_q", longint'(b2.q), m_on ? longint'(1 << m_idx) : 0);
        chk("model_idx", longint'(b2.idx), longint'(m_idx));
        chk("model_wrap", longint'(b2.wrap), longint'(m_wrap));
        checks += 3;
        assert ($onehot0(b1.q)) else begin errors++; $display("FAIL onehot0_n1: q=%0h", b1.q); end
        assert ($onehot0(b2.q)) else begin errors++; $display("FAIL onehot0_n2: q=%0h", b2.q); end
        assert ($onehot0(b3.q)) else begin errors++; $display("FAIL onehot0_n3: q=%0h", b3.q); end
        checks++;
        if (prev_wrap2 && b2.wrap && b2.dwell != '0) begin
            errors++;
            $display("FAIL wrap_twice: wrap=1 on consecutive cycles, required 0");
        end
        prev_wrap2 = b2.wrap;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        {b1.en, b1.mode, b1.sel, b1.sel_valid, b1.dwell} = '0;
        {b2.en, b2.mode, b2.sel, b2.sel_valid, b2.dwell} = '0;
        {b3.en, b3.mode, b3.sel, b3.sel_valid, b3.dwell} = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_q", b2.q, 0);
        chk("reset_idx", b2.idx, 0);
        chk("reset_wrap", b2.wrap, 0);

        // DIRECT decode of every select, then hold with sel_valid low
        b2.en = 1'b1; b2.mode = 1'b0; b2.sel_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            b2.sel = 2'(s);
            tick();
            chk("direct_q", b2.q, longint'(1 << s));
            chk("direct_idx", b2.idx, s);
        end
        b2.sel_valid = 1'b0; b2.sel = 2'd1;
        tick(); tick();
        chk("direct_hold_q", b2.q, 'h8);
        chk("direct_hold_idx", b2.idx, 3);

        // SCAN, dwell 0: advance every cycle, wrap with the second 0001
        b2.dwell = 8'd0; b2.mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("scan0_q", b2.q, longint'(1 << (k % 4)));
            chk("scan0_wrap", b2.wrap, (k == 4) ? 1 : 0);
        end
        tick();
        chk("scan0_after_wrap_q", b2.q, 'h2);
        chk("scan0_after_wrap_wrap", b2.wrap, 0);

        // SCAN, dwell 2: three cycles per index; dwell drops to 0 while on index 1
        b2.en = 1'b0;
        tick();
        chk("off_q", b2.q, 0);
        b2.dwell = 8'd2; b2.en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("scan2_q", b2.q, longint'(1 << ((k / 3) % 4)));
            chk("scan2_wrap", b2.wrap, (k == 12) ? 1 : 0);
        end
        tick();
        chk("scan2_idx1_q", b2.q, 'h2);
        b2.dwell = 8'd0;
        tick(); chk("dwell_chg_hold1", b2.q, 'h2);
        tick(); chk("dwell_chg_hold2", b2.q, 'h2);
        tick(); chk("dwell_chg_idx2", b2.q, 'h4);
        tick(); chk("dwell_chg_idx3", b2.q, 'h8);
        tick(); chk("dwell_chg_wrap_q", b2.q, 'h1); chk("dwell_chg_wrap", b2.wrap, 1);
        tick(); chk("dwell_chg_idx1", b2.q, 'h2);

        // Mode switch at index 2
        tick(); chk("pre_switch_q", b2.q, 'h4);
        b2.mode = 1'b0; b2.sel_valid = 1'b0; b2.sel = 2'd3;
        tick(); chk("switch_hold_q", b2.q, 'h4); chk("switch_hold_idx", b2.idx, 2);
        tick(); chk("switch_hold_q2", b2.q, 'h4);
        b2.sel_valid = 1'b1;
        tick(); chk("switch_load_q", b2.q, 'h8); chk("switch_load_idx", b2.idx, 3);
        b2.sel_valid = 1'b0; b2.mode = 1'b1;
        tick(); chk("rescan_q", b2.q, 'h1); chk("rescan_wrap", b2.wrap, 0);

        // Enable gating at index 3
        tick(); tick(); tick();
        chk("gate_pre_q", b2.q, 'h8);
        b2.en = 1'b0;
        tick(); chk("gate_off_q", b2.q, 0); chk("gate_off_wrap", b2.wrap, 0); chk("gate_off_idx", b2.idx, 3);
        b2.en = 1'b1;
        tick(); chk("gate_restart_q", b2.q, 'h1);

        // OFF -> DIRECT with and without sel_valid on the entry edge
        b2.en = 1'b0;
        tick();
        b2.en = 1'b1; b2.mode = 1'b0; b2.sel_valid = 1'b1; b2.sel = 2'd2;
        tick(); chk("off2direct_sel_q", b2.q, 'h4);
        b2.sel_valid = 1'b0; b2.sel = 2'd0; b2.en = 1'b0;
        tick(); chk("off2direct_off_q", b2.q, 0);
        b2.en = 1'b1;
        tick(); chk("off2direct_keep_q", b2.q, 'h4); chk("off2direct_keep_idx", b2.idx, 2);

        // Asynchronous reset between edges during a scan
        b2.mode = 1'b1; b2.dwell = 8'd1;
        tick(); tick(); tick();
        chk("pre_reset_q", b2.q, 'h2);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_q", b2.q, 0);
        chk("async_reset_idx", b2.idx, 0);
        chk("async_reset_wrap", b2.wrap, 0);
        b2.en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        tick(); chk("post_reset_q", b2.q, 0);
        tick(); chk("post_reset_q2", b2.q, 0);

        // N=1 toggles, N=3 sweeps eight outputs
        b1.en = 1'b1; b1.mode = 1'b1; b1.dwell = 8'd0;
        b3.en = 1'b1; b3.mode = 1'b1; b3.dwell = 8'd0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("n1_q", b1.q, longint'(1 << ((k - 1) % 2)));
            chk("n1_wrap", b1.wrap, (k >= 3 && (k - 1) % 2 == 0) ? 1 : 0);
            chk("n3_q", b3.q, longint'(1 << ((k - 1) % 8)));
            chk("n3_wrap", b3.wrap, (k == 9) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with enable.
- Two modes:
  - DIRECT: decodes a validated select input.
  - SCAN: an internal counter walks the outputs with a programmable dwell time.
- Successor to the team's combinational 2-to-4 decoders.
- Used for row/digit strobing (LED matrix, keypad scan) and for chip-select generation.

Parameters:
- N, default 2: select width; output width is 2^N (localparam OUTW = 1 << N). Legal range 1..6.
- DWELL_W, default 8: width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; 0 forces all outputs off.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- sel  input  N  select index for DIRECT mode.
- sel_valid  input  1  qualifies sel; sampled only in DIRECT mode.
- dwell  input  DWELL_W  in SCAN mode each output stays active for dwell+1 cycles.
- q  output  OUTW  registered decoded output; always all-zero or exactly one-hot.
- idx  output  N  registered index currently driven (valid when q != 0).
- wrap  output  1  one-cycle pulse when SCAN returns from index OUTW-1 to index 0.

Behaviour:
- Reset (async assert, synchronous release):
  - q=0, idx=0, wrap=0, dwell counter cnt=0, state=OFF.
  - Reset asserted mid-operation clears everything on assertion, with no further clock edge needed.
- FSM states: OFF, DIRECT, SCAN. Next state is evaluated every clock edge:
  - en=0 -> OFF.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
- OFF:
  - q=0 and wrap=0; idx and cnt hold.
- DIRECT:
  - q = onehot(idx).
  - When sel_valid=1 on an edge: idx <= sel and q <= onehot(sel). Latency is 1 cycle from the sampling edge to q.
  - When sel_valid=0: idx and q hold.
  - OFF->DIRECT on the same edge as sel_valid=1: the new sel is used. Without sel_valid, the retained idx is driven.
  - wrap=0 throughout.
- SCAN entry (from OFF or DIRECT):
  - On the entry edge: idx<=0, q<=onehot(0), cnt<=dwell, wrap<=0.
- SCAN steady state:
  - If cnt != 0: cnt decrements; idx and q hold.
  - If cnt == 0: idx <= idx+1 modulo OUTW, q <= onehot(idx+1), cnt <= dwell (current input value).
- Advance from OUTW-1 to 0: wrap <= 1 for exactly that cycle, coincident with q=onehot(0).
- dwell=0: the scan advances every cycle (full sweep every OUTW cycles).
- dwell changes mid-scan: the new value takes effect only at the next reload. The current dwell interval is not shortened or extended.
- SCAN->DIRECT: idx retains the last scanned value, and q=onehot(idx) until sel_valid loads a new sel.
- sel and sel_valid are ignored in SCAN and OFF.
- N=1: OUTW=2 and the scan toggles between the two outputs. All rules above still hold.
- Invariant, checked by an assertion in the bench: $onehot0(q) on every cycle. wrap is never 1 for two consecutive cycles when dwell>0.

Decomposition:
- Shared package decoder_pkg:
  - mode encoding constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1;
  - state enum {ST_OFF, ST_DIRECT, ST_SCAN};
  - function onehot(index) returning a 1<<index vector of parametric width.
- One natural sub-module: decoder_n, a purely combinational parametrised N-to-2^N decoder with enable. decoder_scan_n registers its output.
- Dwell counter and FSM stay in the top module.

Test Plan:
- Reset: rst=1 mid-scan, asserted asynchronously between edges -> q=0000, idx=0, wrap=0 immediately; after release with en=0, q stays 0000.
- DIRECT decode, N=2: en=1, mode=0, sel=0..3 each with sel_valid=1 -> q=0001, 0010, 0100, 1000 one cycle after each edge. Drop sel_valid and drive sel=1 -> q holds 1000.
- SCAN dwell=0, N=2: en=1, mode=1 -> q sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles. wrap=1 only on the cycle showing the second 0001.
- SCAN dwell=2: each one-hot value is held 3 cycles, so a full sweep takes 12 cycles. Changing dwell to 0 during index 1 -> index 1 still lasts 3 cycles, then indices advance every cycle.
- Mode switch: in SCAN at idx=2, set mode=0 with sel_valid=0 -> q=0100 held. Then sel=3 with sel_valid=1 -> q=1000. Switch back to mode=1 -> q restarts at 0001.
- Enable gating: en=0 during SCAN at idx=3 -> q=0000 next cycle. en=1 with mode=1 -> scan restarts at 0001. Bench asserts $onehot0(q) on every cycle for N=1, 2 and 3.
